// File: rtl/ysyx_25040129_idu_sb.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_idu_sb
//
// Decode-stage scoreboard and output register. It sits between the IFU and
// the EXU. Every integer register has a small counter of in-flight writes.
// A decoded instruction is held back (in_ready=0) while any of these holds:
//   - a source register still has a pending write,
//   - its destination counter is saturated,
//   - the optional CSR scoreboard reports a pending CSR write.
// Accepted instructions are copied into a registered output stage. Retire
// reports from writeback drain the counters. A flush kills the instruction
// held in the output stage and undoes its counter increment.
//
// Optional feature: define YSYX_25040129_IDU_CSR_SB_EN to track one
// outstanding CSR write (csr_pend). Without it, CSR accesses never stall
// and wb_csr_we is ignored.
//
// Parameters
//   REGS_DIG   register-index width (4 = RV32E, 5 = RV32I)
//   CNT_W      width of each per-register pending-write counter
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         IFU-side handshake
//   rs1, rs2, rd                decoded register indices
//   rs1_use, rs2_use, rd_we     source-use and destination-write flags
//   csr_rd_use, csr_we          CSR read-use and CSR write flags
//   out_valid / out_ready       EXU-side handshake
//   out_rd, out_rd_we,
//   out_csr_we                  registered copy of the accepted fields
//   wb_valid, wb_we, wb_rd,
//   wb_csr_we                   writeback retire reports
//   flush                       kill the instruction held in the output stage
//   sb_err                      sticky counter-underflow flag (until rst)
// ----------------------------------------------------------------------------
module ysyx_25040129_idu_sb #(
   parameter int REGS_DIG = 5,
   parameter int CNT_W    = 2
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                in_valid,
   output logic                in_ready,
   input  logic [REGS_DIG-1:0] rs1,
   input  logic [REGS_DIG-1:0] rs2,
   input  logic [REGS_DIG-1:0] rd,
   input  logic                rs1_use,
   input  logic                rs2_use,
   input  logic                rd_we,
   input  logic                csr_rd_use,
   input  logic                csr_we,

   output logic                out_valid,
   input  logic                out_ready,
   output logic [REGS_DIG-1:0] out_rd,
   output logic                out_rd_we,
   output logic                out_csr_we,

   input  logic                wb_valid,
   input  logic                wb_we,
   input  logic                wb_csr_we,
   input  logic [REGS_DIG-1:0] wb_rd,

   input  logic                flush,
   output logic                sb_err
);

   localparam int              NREG    = 1 << REGS_DIG;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]    cnt_q [NREG];
   logic [CNT_W-1:0]    cnt_d [NREG];
   logic [NREG-1:0]     under;

   logic                out_valid_q;
   logic [REGS_DIG-1:0] out_rd_q;
   logic                out_rd_we_q;
   logic                out_csr_we_q;
   logic                sb_err_q;
   logic                sb_err_d;

   logic                rs1_haz;
   logic                rs2_haz;
   logic                rd_sat;
   logic                csr_hazard;
   logic                hazard;
   logic                fire_in;
   logic                flush_kill;

   // Next counter value from the current value, one possible increment and
   // up to two decrements (writeback retire plus flush revert). The MSB of
   // the result flags an underflow; the count then saturates at zero.
   function automatic logic [CNT_W:0] cnt_next(
      input logic [CNT_W-1:0] cur,
      input logic             inc,
      input logic             dec_a,
      input logic             dec_b
   );
      logic [CNT_W+1:0] up;
      logic [CNT_W+1:0] down;
      up   = {2'b00, cur} + {{(CNT_W+1){1'b0}}, inc};
      down = {{CNT_W{1'b0}}, ({1'b0, dec_a} + {1'b0, dec_b})};
      if (up < down) begin
         cnt_next = {1'b1, {CNT_W{1'b0}}};
      end else begin
         cnt_next = {1'b0, CNT_W'(up - down)};
      end
   endfunction

   // ---------------------------------------------------------------------
   // Hazard detection: only registered counter state is consulted, so a
   // retire becomes visible to a dependent instruction one cycle later.
   // ---------------------------------------------------------------------
   assign rs1_haz = rs1_use & (rs1 != '0) & (cnt_q[rs1] != '0);
   assign rs2_haz = rs2_use & (rs2 != '0) & (cnt_q[rs2] != '0);
   assign rd_sat  = rd_we   & (rd  != '0) & (cnt_q[rd]  == CNT_MAX);
   assign hazard  = rs1_haz | rs2_haz | rd_sat | csr_hazard;

   // rst is folded in so nothing is accepted during the reset cycle.
   assign in_ready   = ~rst & ~hazard & ~flush & (~out_valid_q | out_ready);
   assign fire_in    = in_valid & in_ready;

   // A flush only has to undo work when the EXU has not taken the
   // instruction this cycle; with out_ready high it counts as accepted.
   assign flush_kill = flush & out_valid_q & ~out_ready;

   // ---------------------------------------------------------------------
   // Per-register counter next-state. x0 is never tracked.
   // ---------------------------------------------------------------------
   assign cnt_d[0] = '0;
   assign under[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : g_cnt
      logic           inc;
      logic           dec_wb;
      logic           dec_fl;
      logic [CNT_W:0] nx;

      assign inc    = fire_in & rd_we & (rd == REGS_DIG'(g));
      assign dec_wb = wb_valid & wb_we & (wb_rd == REGS_DIG'(g));
      assign dec_fl = flush_kill & out_rd_we_q & (out_rd_q == REGS_DIG'(g));
      assign nx     = cnt_next(cnt_q[g], inc, dec_wb, dec_fl);

      assign cnt_d[g] = nx[CNT_W-1:0];
      assign under[g] = nx[CNT_W];
   end

   assign sb_err_d = sb_err_q | (|under);

   // ---------------------------------------------------------------------
   // State registers. Priority: rst, then flush, then fire_in.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         out_valid_q  <= 1'b0;
         out_rd_q     <= '0;
         out_rd_we_q  <= 1'b0;
         out_csr_we_q <= 1'b0;
         sb_err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         sb_err_q <= sb_err_d;

         if (flush_kill) begin
            out_valid_q <= 1'b0;
         end else if (fire_in) begin
            out_valid_q  <= 1'b1;
            out_rd_q     <= rd;
            out_rd_we_q  <= rd_we;
            out_csr_we_q <= csr_we;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Optional single-entry CSR scoreboard.
   // ---------------------------------------------------------------------
`ifdef YSYX_25040129_IDU_CSR_SB_EN
   logic csr_pend_q;

   assign csr_hazard = (csr_rd_use | csr_we) & csr_pend_q;

   // A new CSR write wins over a same-cycle CSR retire.
   always_ff @(posedge clk) begin
      if (rst) begin
         csr_pend_q <= 1'b0;
      end else if (fire_in & csr_we) begin
         csr_pend_q <= 1'b1;
      end else if ((wb_valid & wb_csr_we) | (flush_kill & out_csr_we_q)) begin
         csr_pend_q <= 1'b0;
      end
   end
`else
   logic unused_csr;

   assign csr_hazard = 1'b0;
   assign unused_csr = wb_csr_we ^ csr_rd_use;
`endif

   assign out_valid  = out_valid_q;
   assign out_rd     = out_rd_q;
   assign out_rd_we  = out_rd_we_q;
   assign out_csr_we = out_csr_we_q;
   assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_ysyx_25040129_idu_sb.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for ysyx_25040129_idu_sb (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked 2 time
// units after the edge, well clear of the next active edge.
// ----------------------------------------------------------------------------
module tb_ysyx_25040129_idu_sb;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] rs1, rs2, rd;
   logic       rs1_use, rs2_use, rd_we, csr_rd_use, csr_we;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_rd;
   logic       out_rd_we, out_csr_we;
   logic       wb_valid, wb_we, wb_csr_we;
   logic [4:0] wb_rd;
   logic       flush;
   logic       sb_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ysyx_25040129_idu_sb dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rs1        (rs1),
      .rs2        (rs2),
      .rd         (rd),
      .rs1_use    (rs1_use),
      .rs2_use    (rs2_use),
      .rd_we      (rd_we),
      .csr_rd_use (csr_rd_use),
      .csr_we     (csr_we),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rd     (out_rd),
      .out_rd_we  (out_rd_we),
      .out_csr_we (out_csr_we),
      .wb_valid   (wb_valid),
      .wb_we      (wb_we),
      .wb_csr_we  (wb_csr_we),
      .wb_rd      (wb_rd),
      .flush      (flush),
      .sb_err     (sb_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clr_in();
      in_valid   = 1'b0;
      rs1        = '0;
      rs2        = '0;
      rd         = '0;
      rs1_use    = 1'b0;
      rs2_use    = 1'b0;
      rd_we      = 1'b0;
      csr_rd_use = 1'b0;
      csr_we     = 1'b0;
   endtask

   task automatic wb(input logic v, input logic [4:0] r);
      wb_valid = v;
      wb_we    = v;
      wb_rd    = r;
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      flush     = 1'b0;
      wb_csr_we = 1'b0;
      clr_in();
      wb(1'b0, 5'd0);

      // ---------------- reset ----------------
      tick();
      tick();
      in_valid = 1'b1;
      settle();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      clr_in();
      settle();
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_out_rd",     32'(out_rd),     32'd0);
      chk("rst_out_rd_we",  32'(out_rd_we),  32'd0);
      chk("rst_out_csr_we", 32'(out_csr_we), 32'd0);
      chk("rst_sb_err",     32'(sb_err),     32'd0);
      chk("rst_in_ready_1", 32'(in_ready),   32'd1);

      // ---------------- back-to-back RAW on x5 ----------------
      in_valid = 1'b1; rd = 5'd5; rd_we = 1'b1;
      settle();
      chk("raw_issue_ready", 32'(in_ready), 32'd1);
      tick();
      rd_we = 1'b0; rs1 = 5'd5; rs1_use = 1'b1;
      settle();
      chk("raw_out_valid", 32'(out_valid), 32'd1);
      chk("raw_out_rd",    32'(out_rd),    32'd5);
      chk("raw_out_rd_we", 32'(out_rd_we), 32'd1);
      chk("raw_stall0",    32'(in_ready),  32'd0);
      tick();
      settle();
      chk("raw_stall1",    32'(in_ready),  32'd0);
      chk("raw_drain",     32'(out_valid), 32'd0);
      wb(1'b1, 5'd5);
      settle();
      chk("raw_no_bypass", 32'(in_ready),  32'd0);
      tick();
      wb(1'b0, 5'd0);
      settle();
      chk("raw_release",   32'(in_ready),  32'd1);
      tick();
      clr_in();
      settle();
      chk("raw_dep_valid", 32'(out_valid), 32'd1);
      chk("raw_dep_rd_we", 32'(out_rd_we), 32'd0);
      tick();

      // ---------------- saturation on x7 ----------------
      in_valid = 1'b1; rd = 5'd7; rd_we = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("sat_issue", 32'(in_ready), 32'd1);
         tick();
      end
      settle();
      chk("sat_cnt3",   32'(dut.cnt_q[7]), 32'd3);
      chk("sat_stall0", 32'(in_ready),     32'd0);
      tick();
      settle();
      chk("sat_stall1", 32'(in_ready),     32'd0);
      wb(1'b1, 5'd7);
      settle();
      chk("sat_stall_wb", 32'(in_ready),   32'd0);
      tick();
      wb(1'b0, 5'd0);
      settle();
      chk("sat_cnt2",    32'(dut.cnt_q[7]), 32'd2);
      chk("sat_release", 32'(in_ready),     32'd1);
      tick();
      clr_in();
      wb(1'b1, 5'd7);
      tick();
      tick();
      tick();
      wb(1'b0, 5'd0);
      settle();
      chk("sat_drained", 32'(dut.cnt_q[7]), 32'd0);
      chk("sat_no_err",  32'(sb_err),       32'd0);

      // ---------------- simultaneous inc/dec on x7 ----------------
      in_valid = 1'b1; rd = 5'd7; rd_we = 1'b1;
      tick();
      wb(1'b1, 5'd7);
      settle();
      chk("incdec_ready", 32'(in_ready), 32'd1);
      tick();
      clr_in();
      settle();
      chk("incdec_cnt1", 32'(dut.cnt_q[7]), 32'd1);
      tick();
      wb(1'b0, 5'd0);
      settle();
      chk("incdec_cnt0", 32'(dut.cnt_q[7]), 32'd0);
      chk("incdec_err",  32'(sb_err),       32'd0);

      // ---------------- x0 never tracked ----------------
      in_valid = 1'b1; rd = 5'd0; rd_we = 1'b1; rs1_use = 1'b1; rs2_use = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("x0_ready", 32'(in_ready), 32'd1);
         tick();
      end
      clr_in();
      wb(1'b1, 5'd0);
      tick();
      wb(1'b0, 5'd0);
      settle();
      chk("x0_cnt",    32'(dut.cnt_q[0]), 32'd0);
      chk("x0_no_err", 32'(sb_err),       32'd0);

      // ---------------- flush with EXU stalled ----------------
      out_ready = 1'b0;
      in_valid = 1'b1; rd = 5'd3; rd_we = 1'b1;
      settle();
      chk("fl_issue", 32'(in_ready), 32'd1);
      tick();
      clr_in();
      settle();
      chk("fl_valid",    32'(out_valid),    32'd1);
      chk("fl_rd",       32'(out_rd),       32'd3);
      chk("fl_cnt1",     32'(dut.cnt_q[3]), 32'd1);
      chk("fl_backpres", 32'(in_ready),     32'd0);
      tick();
      settle();
      chk("fl_hold_valid", 32'(out_valid), 32'd1);
      chk("fl_hold_rd",    32'(out_rd),    32'd3);
      flush = 1'b1;
      settle();
      chk("fl_ready_low", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      settle();
      chk("fl_killed",  32'(out_valid),    32'd0);
      chk("fl_cnt0",    32'(dut.cnt_q[3]), 32'd0);
      in_valid = 1'b1; rs2 = 5'd3; rs2_use = 1'b1; rd = 5'd4; rd_we = 1'b1;
      settle();
      chk("fl_reader", 32'(in_ready), 32'd1);
      tick();
      clr_in();
      settle();
      chk("fl_rd_valid", 32'(out_valid),    32'd1);
      chk("fl_rd4",      32'(out_rd),       32'd4);
      chk("fl_cnt4",     32'(dut.cnt_q[4]), 32'd1);
      // flush in the same cycle the EXU takes it: nothing is reverted
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      settle();
      chk("fla_valid", 32'(out_valid),    32'd0);
      chk("fla_cnt4",  32'(dut.cnt_q[4]), 32'd1);
      wb(1'b1, 5'd4);
      tick();
      wb(1'b0, 5'd0);
      settle();
      chk("fla_cnt4_0", 32'(dut.cnt_q[4]), 32'd0);

      // ---------------- flush revert + retire to same register ----------------
      out_ready = 1'b0;
      in_valid = 1'b1; rd = 5'd6; rd_we = 1'b1;
      tick();
      clr_in();
      flush = 1'b1;
      wb(1'b1, 5'd6);
      tick();
      flush = 1'b0;
      wb(1'b0, 5'd0);
      settle();
      chk("dd_cnt6",  32'(dut.cnt_q[6]), 32'd0);
      chk("dd_err",   32'(sb_err),       32'd1);
      chk("dd_valid", 32'(out_valid),    32'd0);
      out_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk("dd_err_clr", 32'(sb_err), 32'd0);

      // ---------------- underflow on x9 ----------------
      wb(1'b1, 5'd9);
      tick();
      wb(1'b0, 5'd0);
      settle();
      chk("uf_err",  32'(sb_err),       32'd1);
      chk("uf_cnt9", 32'(dut.cnt_q[9]), 32'd0);
      tick();
      tick();
      settle();
      chk("uf_sticky", 32'(sb_err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk("uf_clr", 32'(sb_err), 32'd0);

      // ---------------- CSR path ----------------
      in_valid = 1'b1; csr_we = 1'b1;
      settle();
      chk("csr_issue", 32'(in_ready), 32'd1);
      tick();
      csr_we = 1'b0; csr_rd_use = 1'b1;
      settle();
      chk("csr_out_we", 32'(out_csr_we), 32'd1);
`ifdef YSYX_25040129_IDU_CSR_SB_EN
      chk("csr_stall0", 32'(in_ready), 32'd0);
      tick();
      settle();
      chk("csr_stall1", 32'(in_ready), 32'd0);
      wb_valid = 1'b1; wb_csr_we = 1'b1;
      tick();
      wb_valid = 1'b0; wb_csr_we = 1'b0;
      settle();
      chk("csr_release", 32'(in_ready), 32'd1);
      tick();
`else
      chk("csr_nostall", 32'(in_ready), 32'd1);
      tick();
`endif
      clr_in();
      settle();
      chk("csr_rd_valid",  32'(out_valid),  32'd1);
      chk("csr_rd_out_we", 32'(out_csr_we), 32'd0);
      tick();

      // ---------------- reset mid-operation ----------------
      out_ready = 1'b0;
      in_valid = 1'b1; rd = 5'd2; rd_we = 1'b1;
      tick();
      settle();
      chk("mr_cnt2",  32'(dut.cnt_q[2]), 32'd1);
      chk("mr_valid", 32'(out_valid),    32'd1);
      rst = 1'b1;
      out_ready = 1'b1;
      settle();
      chk("mr_ready_low", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      clr_in();
      settle();
      chk("mr_out_valid", 32'(out_valid),    32'd0);
      chk("mr_cnt2_0",    32'(dut.cnt_q[2]), 32'd0);
      chk("mr_out_rd",    32'(out_rd),       32'd0);
      chk("mr_out_rd_we", 32'(out_rd_we),    32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_25040129_idu_sb.md
YSYX_25040129_IDU_SB -- requirements
Module: ysyx_25040129_IDU_SB

Interface
REQ-001 SHALL have parameter REGS_DIG, default 5, register-index width (4 = RV32E, 5 = RV32I).
REQ-002 SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports in_valid in 1 / in_ready out 1; this is the IFU-side handshake for a decoded instruction.
REQ-006 SHALL have ports rs1, rs2, rd in REGS_DIG, plus rs1_use, rs2_use, rd_we, csr_rd_use, csr_we in 1 each; these are the decoded operand fields.
REQ-007 SHALL have ports out_valid out 1 / out_ready in 1; this is the EXU-side handshake.
REQ-008 SHALL have ports out_rd out REGS_DIG and out_rd_we, out_csr_we out 1; these are the registered copy of the accepted fields.
REQ-009 SHALL have ports wb_valid, wb_we, wb_csr_we in 1 and wb_rd in REGS_DIG; these are writeback retire reports.
REQ-010 SHALL have port flush  in  1  kills the instruction held in the output stage.
REQ-011 SHALL have port sb_err  out  1  sticky scoreboard underflow flag.

Function
REQ-012 SHALL hold 2^REGS_DIG counters of CNT_W bits each; counter 0 is permanently 0 and x0 is never tracked.
REQ-013 SHALL define hazard as (rs1_use & rs1!=0 & cnt[rs1]!=0) | (rs2_use & rs2!=0 & cnt[rs2]!=0) | (rd_we & rd!=0 & cnt[rd]==2^CNT_W-1) | csr_hazard; the third term is a saturation stall.
REQ-014 SHALL drive in_ready = ~hazard & ~flush & (~out_valid | out_ready), with no combinational dependence on in_valid.
REQ-015 SHALL define fire_in = in_valid & in_ready; on fire_in, the output register loads the fields and out_valid=1 on the next cycle (latency 1).
REQ-016 SHALL clear out_valid when out_valid & out_ready & ~fire_in; out_* SHALL hold their value while out_valid & ~out_ready.
REQ-017 SHALL increment cnt[rd] on fire_in & rd_we & rd!=0.
REQ-018 SHALL decrement cnt[wb_rd] on wb_valid & wb_we & wb_rd!=0.
REQ-019 SHALL leave the counter unchanged when an increment and a decrement target the same register in the same cycle.
REQ-020 SHALL use only registered counter values for hazard evaluation, with no same-cycle retire bypass: a dependent instruction issues at the earliest one cycle after the retire.
REQ-021 SHALL, on a retire to a register whose counter is 0, leave the counter at 0 and set sb_err=1 until reset.
REQ-022 SHALL, on flush with out_valid & ~out_ready, clear out_valid and decrement cnt[out_rd] if out_rd_we & out_rd!=0 (also clearing the CSR pending bit if out_csr_we).
REQ-023 SHALL, on flush with out_valid & out_ready, treat the instruction as accepted and revert nothing.
REQ-024 SHALL apply a flush revert and a wb decrement to the same register in the same cycle as two decrements, saturating at 0 with sb_err set on underflow.
REQ-025 SHALL give rst priority over flush, which has priority over fire_in.

Reset
REQ-026 SHALL, with rst=1, on the next edge set all counters to 0, out_valid=0, out_rd=0, out_rd_we=0, out_csr_we=0, sb_err=0, and the CSR pending bit to 0.
REQ-027 SHALL discard an in-flight instruction when rst is asserted mid-operation, with in_ready=0 during the rst cycle.

Configuration
REQ-028 SHALL, with YSYX_25040129_IDU_CSR_SB_EN defined, keep a 1-bit csr_pend that is set on fire_in & csr_we and cleared on wb_valid & wb_csr_we (set wins when both occur in the same cycle).
REQ-029 SHALL, with the macro defined, set csr_hazard = (csr_rd_use | csr_we) & csr_pend.
REQ-030 SHALL, without the macro, force csr_hazard=0, omit csr_pend, and ignore wb_csr_we; out_csr_we still SHALL mirror csr_we.

Verification
REQ-031 SHALL cover back-to-back RAW: issue rd=5 rd_we, then rs1=5 rs1_use; second stalls (in_ready=0) until wb_rd=5 retires, then in_ready=1 one cycle later.
REQ-032 SHALL cover saturation: three issues with rd=7 and no retire (CNT_W=2) give cnt=3; a fourth rd_we=7 stalls, a single wb_rd=7 releases it.
REQ-033 SHALL cover x0: rd=0 and rs1=0 at any rate never stall, and cnt[0] stays 0.
REQ-034 SHALL cover flush: hold out_valid with out_ready=0 and out_rd=3 (cnt[3]=1), assert flush; next cycle out_valid=0, cnt[3]=0, and a reader of x3 issues.
REQ-035 SHALL cover underflow: wb_valid & wb_we & wb_rd=9 with cnt[9]=0 gives sb_err=1, held until rst, after which sb_err=0.
REQ-036 SHALL cover the CSR path (macro on): csr_we issue, then csr_rd_use stalls until wb_csr_we; with the macro off, the same stimulus issues without stalling.
